multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the 16-bit datapath and drives the registered ALU's `control` input, operand-select muxes and all write enables. It sits directly upstream of the ALU. Because the ALU registers `result` and `isZero` on `posedge clock`, every ALU-dependent action is scheduled one state after the operation is issued. The block also keeps a retired-instruction count.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/ctrl_decode.sv | 106 ++++++++++
 rtl/multicycle_ctrl.sv | 90 +++++++++
 tb/tb_multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multi-cycle controller: ALU codes,
// opcodes, FSM state encoding, datapath mux selects and the control bundle.
package cpu_pkg;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SL  = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] HALT_OP  = 4'hF;

  // ALU operand A select
  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_TWO    = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_TARGET = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       target_write;
    logic       mem_read;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic       illegal;
    logic       halted;
    logic       retire;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_J) || (op == HALT_OP);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: state, opcode, funct and the registered ALU
// zero flag in, control bundle and next state out.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       iszero,
  output ctrl_t      ctrl,
  output state_t     next_state
);

  // Per-state output decode and transition selection
  always_comb begin
    ctrl       = '0;
    next_state = S_FETCH;
    case (state)
      S_FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src_a   = SRC_A_PC;
        ctrl.alu_src_b   = SRC_B_TWO;
        ctrl.alu_control = ALU_ADD;
        next_state       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.pc_write    = 1'b1;
        ctrl.pc_source   = PCSRC_ALU;
        ctrl.alu_src_a   = SRC_A_PC;
        ctrl.alu_src_b   = SRC_B_IMM_SH;
        ctrl.alu_control = ALU_ADD;
        if (opcode == HALT_OP) begin
          next_state = S_HALT;
        end else if (!is_legal(opcode)) begin
          ctrl.illegal = 1'b1;
          next_state   = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        // Target register latches the branch target computed in DECODE
        ctrl.target_write = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            ctrl.alu_src_a   = SRC_A_REG;
            ctrl.alu_src_b   = SRC_B_REG;
            ctrl.alu_control = funct;
            next_state       = S_WB;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctrl.alu_src_a   = SRC_A_REG;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_control = ALU_ADD;
            next_state       = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            ctrl.alu_src_a   = SRC_A_REG;
            ctrl.alu_src_b   = SRC_B_REG;
            ctrl.alu_control = ALU_SUB;
            next_state       = S_BRANCH;
          end
          OP_J: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.retire    = 1'b1;
            next_state     = S_FETCH;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        ctrl.iord = 1'b1;
        if (opcode == OP_LW) begin
          ctrl.mem_read = 1'b1;
          next_state    = S_WB;
        end else begin
          ctrl.mem_write = 1'b1;
          ctrl.retire    = 1'b1;
          next_state     = S_FETCH;
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
        ctrl.mem_to_reg = (opcode == OP_LW);
        ctrl.reg_dst    = (opcode == OP_RTYPE);
        next_state      = S_FETCH;
      end
      S_BRANCH: begin
        // isZero now holds the result of the EXEC subtraction
        ctrl.pc_write  = (opcode == OP_BEQ) ? iszero : !iszero;
        ctrl.pc_source = PCSRC_TARGET;
        ctrl.retire    = 1'b1;
        next_state     = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        next_state  = S_HALT;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle controller top: state register, retired-instruction counter and
// reset masking around the combinational decode.
//
//   state  | meaning
//   FETCH  | read instruction into IR, ALU forms PC+2
//   DECODE | PC <= PC+2, ALU forms branch target
//   EXEC   | latch target, issue ALU op (or jump)
//   MEM    | data memory access for lw/sw
//   WB     | register file write
//   BRANCH | conditional PC load from target register
//   HALT   | parked until reset
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        isZero,
  output logic [2:0]  alu_control,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        target_write,
  output logic        mem_read,
  output logic        iord,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic        halted,
  output logic        retire,
  output logic [15:0] instr_count
);

  state_t      state_q;
  state_t      state_d;
  state_t      dec_state;
  ctrl_t       ctrl;
  logic [15:0] instr_count_q;

  // While reset is held, the datapath sees the FETCH decode
  assign dec_state = reset ? S_FETCH : state_q;

  ctrl_decode u_decode (
    .state      (dec_state),
    .opcode     (opcode),
    .funct      (funct),
    .iszero     (isZero),
    .ctrl       (ctrl),
    .next_state (state_d)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clock) begin
    if (reset) instr_count_q <= '0;
    else       instr_count_q <= instr_count_q + {15'd0, ctrl.retire};
  end

  assign alu_control  = ctrl.alu_control;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign mem_read     = ctrl.mem_read;
  assign iord         = ctrl.iord;
  assign mem_to_reg   = ctrl.mem_to_reg;
  assign reg_dst      = ctrl.reg_dst;
  assign pc_source    = ctrl.pc_source;
  assign halted       = ctrl.halted;

  // Write enables and pulses are suppressed during reset
  assign pc_write     = ctrl.pc_write     & ~reset;
  assign ir_write     = ctrl.ir_write     & ~reset;
  assign reg_write    = ctrl.reg_write    & ~reset;
  assign mem_write    = ctrl.mem_write    & ~reset;
  assign target_write = ctrl.target_write & ~reset;
  assign retire       = ctrl.retire       & ~reset;
  assign illegal      = ctrl.illegal      & ~reset;

  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output sequences built
// from the instruction-level behaviour, random instruction stream plus
// directed reset, halt, illegal and counter-wrap cases.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic        isZero;
  logic [2:0]  alu_control;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, ir_write, reg_write, mem_write, target_write;
  logic        mem_read, iord, mem_to_reg, reg_dst;
  logic [1:0]  pc_source;
  logic        illegal, halted, retire;
  logic [15:0] instr_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_count;

  typedef struct packed {
    logic [2:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       target_write;
    logic       mem_read;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic       illegal;
    logic       halted;
    logic       retire;
  } exp_t;

  always #5 clock = ~clock;

  multicycle_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .isZero       (isZero),
    .alu_control  (alu_control),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .target_write (target_write),
    .mem_read     (mem_read),
    .iord         (iord),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .pc_source    (pc_source),
    .illegal      (illegal),
    .halted       (halted),
    .retire       (retire),
    .instr_count  (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {12'd0, alu_control, alu_src_a, alu_src_b, pc_write, ir_write, reg_write,
            mem_write, target_write, mem_read, iord, mem_to_reg, reg_dst,
            pc_source, illegal, halted, retire};
  endfunction

  function automatic int latency(input int op);
    case (op)
      0, 1, 3, 4, 5: return 4;
      2:             return 5;
      6:             return 3;
      default:       return 2;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction (k=0 is its fetch cycle)
  function automatic exp_t expect_at(input int op, input int f, input bit z, input int k);
    exp_t e;
    e = '0;
    if (k == 0) begin
      e.mem_read = 1; e.ir_write = 1; e.src_b = 1; e.alu = 2;
    end else if (k == 1) begin
      e.pc_write = 1; e.src_b = 3; e.alu = 2;
      e.illegal = !(op <= 6 || op == 15);
    end else if (k == 2) begin
      e.target_write = 1;
      case (op)
        0:       begin e.src_a = 1; e.alu = f[2:0]; end
        1, 2, 3: begin e.src_a = 1; e.src_b = 2; e.alu = 2; end
        4, 5:    begin e.src_a = 1; e.alu = 3; end
        6:       begin e.pc_write = 1; e.pc_source = 2; e.retire = 1; end
        default: ;
      endcase
    end else if (k == 3) begin
      case (op)
        0, 1: begin e.reg_write = 1; e.retire = 1; e.reg_dst = (op == 0); end
        2:    begin e.iord = 1; e.mem_read = 1; end
        3:    begin e.iord = 1; e.mem_write = 1; e.retire = 1; end
        4, 5: begin e.pc_write = (op == 4) ? z : !z; e.pc_source = 1; e.retire = 1; end
        default: ;
      endcase
    end else if (k == 4) begin
      e.reg_write = 1; e.retire = 1; e.mem_to_reg = 1;
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, compare at negedge, advance model count
  task automatic step_cycle(input string tag, input logic [3:0] op, input logic [2:0] f,
                            input logic z, input exp_t e);
    opcode = op;
    funct  = f;
    isZero = z;
    @(negedge clock);
    chk(tag, obs_vec(), {12'd0, e});
    chk({tag, "_cnt"}, {16'd0, instr_count}, {16'd0, m_count});
    if (e.retire) m_count = m_count + 16'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input string tag, input int op, input int f, input bit z);
    int n;
    logic zd;
    n = latency(op);
    for (int k = 0; k < n; k++) begin
      zd = ((op == 4 || op == 5) && k == 3) ? z : 1'($urandom);
      step_cycle(tag, (k == 0) ? 4'($urandom) : 4'(op), 3'(f), zd, expect_at(op, f, z, k));
    end
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '0;
    e.mem_read = 1; e.src_b = 1; e.alu = 2;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode = 4'($urandom);
      isZero = 1'($urandom);
      @(negedge clock);
      chk("reset_out", obs_vec(), {12'd0, e});
      @(posedge clock);
      #1;
    end
    m_count = 16'd0;
    chk("reset_cnt", {16'd0, instr_count}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    exp_t hx;
    int   op;
    reset  = 1'b1;
    opcode = 4'd0;
    funct  = 3'd0;
    isZero = 1'b0;
    m_count = 16'd0;
    @(posedge clock);
    #1;
    do_reset(2);

    // Reset mid-EXEC of an R-type: abandoned with no write
    run_instr("rtype_pre", 0, 1, 0);
    step_cycle("abort_f", 4'h0, 3'd2, 1'b0, expect_at(0, 2, 0, 0));
    step_cycle("abort_d", 4'h0, 3'd2, 1'b0, expect_at(0, 2, 0, 1));
    do_reset(1);

    // Directed instructions
    run_instr("rtype_sra", 0, 6, 0);
    chk("cnt_after_r", {16'd0, instr_count}, 32'd1);
    run_instr("lw", 2, 0, 0);
    run_instr("sw", 3, 0, 0);
    chk("cnt_after_lwsw", {16'd0, instr_count}, 32'd3);
    run_instr("beq_z1", 4, 0, 1);
    run_instr("bne_z1", 5, 0, 1);
    run_instr("beq_z0", 4, 0, 0);
    run_instr("bne_z0", 5, 0, 0);
    run_instr("illegal9", 9, 0, 0);
    chk("cnt_after_ill", {16'd0, instr_count}, 32'd7);
    run_instr("addi", 1, 0, 0);
    run_instr("j", 6, 0, 0);

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      if (op >= 7) op = (op == 9) ? int'($urandom_range(0, 6)) : int'($urandom_range(7, 14));
      run_instr("rand", op, int'($urandom_range(0, 7)), 1'($urandom));
    end

    // Halt: parked with halted=1, no enables, until reset
    step_cycle("halt_f", 4'h0, 3'd0, 1'b0, expect_at(15, 0, 0, 0));
    step_cycle("halt_d", 4'hF, 3'd0, 1'b0, expect_at(15, 0, 0, 1));
    hx = '0;
    hx.halted = 1;
    for (int i = 0; i < 20; i++)
      step_cycle("halt_hold", 4'($urandom), 3'($urandom), 1'($urandom), hx);
    do_reset(1);
    run_instr("post_halt", 1, 0, 0);

    // Counter wrap: preload near the top, then retire two jumps
    force dut.instr_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    step_cycle("wrap_j0", 4'h0, 3'd0, 1'b0, expect_at(6, 0, 0, 0));
    release dut.instr_count_q;
    step_cycle("wrap_j0", 4'h6, 3'd0, 1'b0, expect_at(6, 0, 0, 1));
    step_cycle("wrap_j0", 4'h6, 3'd0, 1'b0, expect_at(6, 0, 0, 2));
    chk("cnt_ffff", {16'd0, instr_count}, 32'h0000FFFF);
    run_instr("wrap_j1", 6, 0, 0);
    chk("cnt_wrap0", {16'd0, instr_count}, 32'd0);
    run_instr("after_wrap", 3, 0, 0);
    chk("cnt_after_wrap", {16'd0, instr_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
